// File: rtl/c64_bus_pkg.sv
// c64_bus_pkg -- shared definitions for the C64 bus arbiter slice.
//   arb_state_t      : arbiter ownership states (IDLE, BA_WAIT, VIC_OWN)
//   PHASE_VIC/CPU    : meaning of the phase bit (0 = phi1/VIC, 1 = phi2/CPU)
//   DEFAULT_BA_DELAY : CPU cycles granted after a DMA request before takeover
//   DEFAULT_STOLEN_W : width of the stolen-cycle counter
package c64_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // normal two-phase sharing
        BA_WAIT = 2'd1,  // CPU told to stop (BA low) but still owns phi2
        VIC_OWN = 2'd2   // VIC owns both phases
    } arb_state_t;

    localparam logic PHASE_VIC = 1'b0;
    localparam logic PHASE_CPU = 1'b1;

    localparam int DEFAULT_BA_DELAY = 3;
    localparam int DEFAULT_STOLEN_W = 8;

endpackage

// File: rtl/c64_bus_arbiter_if.sv
// c64_bus_arbiter_if -- every bus-side signal around the arbiter.
//   CPU side : cpu_ab, cpu_do, cpu_we (to arbiter); cpu_di, cpu_ce, cpu_rdy (from)
//   VIC side : vic_addr, vic_ba_req (to arbiter); vic_di (from)
//   Memory   : mem_rdata (to arbiter); aec, mem_addr, mem_wdata, mem_we (from)
//   Status   : stolen_cnt (from arbiter)
// slave  = the arbiter's view; master = the CPU/VIC/memory environment view.
interface c64_bus_arbiter_if
    import c64_bus_pkg::*;
#(
    parameter int STOLEN_W = DEFAULT_STOLEN_W
);
    logic [15:0]         cpu_ab;
    logic [7:0]          cpu_do;
    logic                cpu_we;
    logic [7:0]          cpu_di;
    logic                cpu_ce;
    logic                cpu_rdy;
    logic [15:0]         vic_addr;
    logic                vic_ba_req;
    logic [7:0]          vic_di;
    logic                aec;
    logic [15:0]         mem_addr;
    logic [7:0]          mem_wdata;
    logic                mem_we;
    logic [7:0]          mem_rdata;
    logic [STOLEN_W-1:0] stolen_cnt;

    modport slave (
        input  cpu_ab, cpu_do, cpu_we, vic_addr, vic_ba_req, mem_rdata,
        output cpu_di, cpu_ce, cpu_rdy, vic_di, aec,
               mem_addr, mem_wdata, mem_we, stolen_cnt
    );

    modport master (
        output cpu_ab, cpu_do, cpu_we, vic_addr, vic_ba_req, mem_rdata,
        input  cpu_di, cpu_ce, cpu_rdy, vic_di, aec,
               mem_addr, mem_wdata, mem_we, stolen_cnt
    );
endinterface

// File: rtl/c64_phase_gen.sv
// c64_phase_gen -- two-phase sequencer for the shared bus.
//   clk          : system clock, one clk = one phase
//   reset        : asynchronous, active-low
//   phase        : 0 = VIC half (phi1), 1 = CPU half (phi2); 0 first after reset
//   cpu_half_end : high during a CPU half, i.e. the coming edge ends phi2
module c64_phase_gen
    import c64_bus_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic phase,
    output logic cpu_half_end
);

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PHASE_VIC;
        end else begin
            phase <= ~phase;
        end
    end

    assign cpu_half_end = (phase == PHASE_CPU);

endmodule

// File: rtl/c64_bus_arbiter.sv
// c64_bus_arbiter -- shares the system bus between the 6502 core and VIC-II.
// phi1 (phase 0) belongs to VIC, phi2 (phase 1) to the CPU. A VIC DMA request
// drops cpu_rdy, lets the CPU run BA_DELAY more phi2 halves, then gives VIC
// both phases until the request falls.
//   clk, reset : system clock (one clk per phase), async active-low reset
//   bus        : c64_bus_arbiter_if.slave -- CPU, VIC and memory signals
// Parameters:
//   BA_DELAY   : phi2 halves still granted to the CPU after the request
//   STOLEN_W   : width of the saturating stolen-cycle counter
module c64_bus_arbiter
    import c64_bus_pkg::*;
#(
    parameter int BA_DELAY = DEFAULT_BA_DELAY,
    parameter int STOLEN_W = DEFAULT_STOLEN_W
)(
    input  logic                  clk,
    input  logic                  reset,
    c64_bus_arbiter_if.slave      bus
);

    localparam int CNT_W = (BA_DELAY > 1) ? $clog2(BA_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BA_DELAY - 1);

    logic                phase;
    logic                cpu_half_end;
    arb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                aec;
    logic [15:0]         mem_addr;
    logic [7:0]          mem_wdata;
    logic                mem_we;
    logic [7:0]          cpu_di_q;
    logic [7:0]          vic_di_q;
    logic [STOLEN_W-1:0] stolen_q;

    c64_phase_gen u_phase_gen (
        .clk          (clk),
        .reset        (reset),
        .phase        (phase),
        .cpu_half_end (cpu_half_end)
    );

    // ------------------------------------------------------------------
    // Ownership FSM: decisions only at the edge ending a CPU half, so a
    // request wiggling inside a pair is never seen.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output of this
        // block; a missing assignment would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cpu_half_end) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.vic_ba_req) begin
                        state_d = BA_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
                BA_WAIT: begin
                    if (!bus.vic_ba_req) begin
                        state_d = IDLE;             // request withdrawn
                    end else if (cnt_q == '0) begin
                        state_d = VIC_OWN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                VIC_OWN: begin
                    if (!bus.vic_ba_req) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus mux: CPU drives only its own phase and never while VIC owns it.
    // VIC is read-only, so its write data and strobe are forced low.
    // ------------------------------------------------------------------
    assign aec = (phase == PHASE_CPU) && (state_q != VIC_OWN);

    always_comb begin
        mem_addr  = bus.vic_addr;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (aec) begin
            mem_addr  = bus.cpu_ab;
            mem_wdata = bus.cpu_do;
            mem_we    = bus.cpu_we;
        end
    end

    // ------------------------------------------------------------------
    // Read capture and stolen-cycle count. Read data is steered by who
    // owned the half that is ending; the other latch keeps its value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_di_q <= '0;
            vic_di_q <= '0;
        end else if (aec) begin
            cpu_di_q <= bus.mem_rdata;
        end else begin
            vic_di_q <= bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stolen_q <= '0;
        end else if (cpu_half_end && (state_q == VIC_OWN) && (stolen_q != '1)) begin
            stolen_q <= stolen_q + STOLEN_W'(1);
        end
    end

    assign bus.aec        = aec;
    assign bus.cpu_ce     = aec;
    assign bus.cpu_rdy    = (state_q == IDLE);
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_we     = mem_we;
    assign bus.cpu_di     = cpu_di_q;
    assign bus.vic_di     = vic_di_q;
    assign bus.stolen_cnt = stolen_q;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb_c64_bus_arbiter -- self-checking bench for c64_bus_arbiter.
// Two instances share clk/reset and stimulus: STOLEN_W=8 and STOLEN_W=4.
// Every clock is compared against a reference model that tracks ownership
// as "number of consecutive phi2 ends that saw the request high".
module tb_c64_bus_arbiter;

    localparam int BA = 3;

    logic clk;
    logic reset;

    c64_bus_arbiter_if #(.STOLEN_W(8)) bus8 ();
    c64_bus_arbiter_if #(.STOLEN_W(4)) bus4 ();

    c64_bus_arbiter #(.BA_DELAY(BA), .STOLEN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    c64_bus_arbiter #(.BA_DELAY(BA), .STOLEN_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic       m_phase;
    int         m_streak;   // consecutive phi2 ends with request high
    int         m_stolen8;
    int         m_stolen4;
    logic [7:0] m_cpu_di;
    logic [7:0] m_vic_di;

    // Observations of the last tick (sampled #1 after the negedge)
    logic        obs_phase;
    logic        obs_aec;
    logic        obs_rdy;
    logic [15:0] obs_addr;
    logic [7:0]  obs_wdata;
    logic        obs_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 1'b0;
        m_streak  = 0;
        m_stolen8 = 0;
        m_stolen4 = 0;
        m_cpu_di  = 8'h00;
        m_vic_di  = 8'h00;
    endtask

    task automatic drive(input logic [15:0] ab, input logic [7:0] d, input logic we,
                         input logic [15:0] va, input logic req, input logic [7:0] rd);
        bus8.cpu_ab = ab;  bus8.cpu_do = d;  bus8.cpu_we = we;
        bus8.vic_addr = va; bus8.vic_ba_req = req; bus8.mem_rdata = rd;
        bus4.cpu_ab = ab;  bus4.cpu_do = d;  bus4.cpu_we = we;
        bus4.vic_addr = va; bus4.vic_ba_req = req; bus4.mem_rdata = rd;
    endtask

    // One clk: called at a negedge, drives, checks against the model,
    // steps the model across the posedge, returns at the next negedge.
    task automatic tick(input logic [15:0] ab, input logic [7:0] d, input logic we,
                        input logic [15:0] va, input logic req, input logic [7:0] rd);
        logic        vic_own;
        logic        e_aec;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        logic        e_we;
        logic        e_rdy;
        drive(ab, d, we, va, req, rd);
        #1;
        vic_own = (m_streak > BA);
        e_aec   = m_phase && !vic_own;
        e_addr  = e_aec ? ab : va;
        e_wd    = e_aec ? d : 8'h00;
        e_we    = e_aec && we;
        e_rdy   = (m_streak == 0);
        check("aec",        32'(bus8.aec),        32'(e_aec));
        check("aec_w4",     32'(bus4.aec),        32'(e_aec));
        check("cpu_ce",     32'(bus8.cpu_ce),     32'(e_aec));
        check("cpu_rdy",    32'(bus8.cpu_rdy),    32'(e_rdy));
        check("mem_addr",   32'(bus8.mem_addr),   32'(e_addr));
        check("mem_wdata",  32'(bus8.mem_wdata),  32'(e_wd));
        check("mem_we",     32'(bus8.mem_we),     32'(e_we));
        check("cpu_di",     32'(bus8.cpu_di),     32'(m_cpu_di));
        check("vic_di",     32'(bus8.vic_di),     32'(m_vic_di));
        check("stolen8",    32'(bus8.stolen_cnt), 32'(m_stolen8));
        check("stolen4",    32'(bus4.stolen_cnt), 32'(m_stolen4));
        obs_phase = m_phase;
        obs_aec   = bus8.aec;
        obs_rdy   = bus8.cpu_rdy;
        obs_addr  = bus8.mem_addr;
        obs_wdata = bus8.mem_wdata;
        obs_we    = bus8.mem_we;
        @(posedge clk);
        if (e_aec) m_cpu_di = rd;
        else       m_vic_di = rd;
        if (m_phase) begin
            if (vic_own) begin
                if (m_stolen8 < 255) m_stolen8++;
                if (m_stolen4 < 15)  m_stolen4++;
            end
            m_streak = req ? ((m_streak < BA + 1) ? m_streak + 1 : m_streak) : 0;
        end
        m_phase = !m_phase;
        @(negedge clk);
    endtask

    task automatic tick_rand(input logic req);
        tick(16'($urandom), 8'($urandom), 1'($urandom), 16'($urandom), req, 8'($urandom));
    endtask

    // Asynchronous reset mid-phase, checked before any clock edge, then
    // released on a negedge so the next clk is the first (phase 0) half.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        drive(16'hBEEF, 8'h55, 1'b1, 16'h1234, 1'b1, 8'hFF);
        reset = 1'b0;
        #1;
        check({tag, "_aec"},     32'(bus8.aec),        32'd0);
        check({tag, "_mem_we"},  32'(bus8.mem_we),     32'd0);
        check({tag, "_cpu_ce"},  32'(bus8.cpu_ce),     32'd0);
        check({tag, "_cpu_rdy"}, 32'(bus8.cpu_rdy),    32'd1);
        check({tag, "_rdy_w4"},  32'(bus4.cpu_rdy),    32'd1);
        check({tag, "_stolen"},  32'(bus8.stolen_cnt), 32'd0);
        check({tag, "_stol_w4"}, 32'(bus4.stolen_cnt), 32'd0);
        check({tag, "_cpu_di"},  32'(bus8.cpu_di),     32'd0);
        check({tag, "_vic_di"},  32'(bus8.vic_di),     32'd0);
        check({tag, "_addr"},    32'(bus8.mem_addr),   32'h1234);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] cpu_ab;
        logic [7:0]  cpu_do;
        logic        cpu_we;
        logic [15:0] vic_addr;
        logic [7:0]  rdata;
        logic        exp_aec;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wdata;
        logic        exp_we;
        logic [7:0]  exp_cpu_di;   // after the edge ending this half
        logic [7:0]  exp_vic_di;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int first_low;
        int ba_halves;
        int late_cpu;
        int lost_cpu;
        int rdy_low;
        logic aec_back;
        logic req;

        reset = 1'b0;
        model_reset();
        drive(16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);

        // Idle bus mux and read capture; phase 0 is the first half.
        vecs[0] = '{16'hD020, 8'h05, 1'b1, 16'h0400, 8'h20, 1'b0, 16'h0400, 8'h00, 1'b0, 8'h00, 8'h20};
        vecs[1] = '{16'hD020, 8'h05, 1'b1, 16'h0400, 8'hA9, 1'b1, 16'hD020, 8'h05, 1'b1, 8'hA9, 8'h20};
        vecs[2] = '{16'h1234, 8'hFF, 1'b0, 16'h3FFF, 8'h5A, 1'b0, 16'h3FFF, 8'h00, 1'b0, 8'hA9, 8'h5A};
        vecs[3] = '{16'h1234, 8'hFF, 1'b0, 16'h3FFF, 8'hC3, 1'b1, 16'h1234, 8'hFF, 1'b0, 8'hC3, 8'h5A};
        vecs[4] = '{16'hFFFF, 8'h80, 1'b1, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hC3, 8'h00};
        vecs[5] = '{16'hFFFF, 8'h80, 1'b1, 16'h0000, 8'h7E, 1'b1, 16'hFFFF, 8'h80, 1'b1, 8'h7E, 8'h00};

        do_reset("rst0");
        for (int i = 0; i < 6; i++) begin
            tick(vecs[i].cpu_ab, vecs[i].cpu_do, vecs[i].cpu_we, vecs[i].vic_addr, 1'b0, vecs[i].rdata);
            check($sformatf("vec%0d_aec", i),    32'(obs_aec),     32'(vecs[i].exp_aec));
            check($sformatf("vec%0d_addr", i),   32'(obs_addr),    32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_wdata", i),  32'(obs_wdata),   32'(vecs[i].exp_wdata));
            check($sformatf("vec%0d_we", i),     32'(obs_we),      32'(vecs[i].exp_we));
            check($sformatf("vec%0d_cpu_di", i), 32'(bus8.cpu_di), 32'(vecs[i].exp_cpu_di));
            check($sformatf("vec%0d_vic_di", i), 32'(bus8.vic_di), 32'(vecs[i].exp_vic_di));
        end

        // Short request (2 pairs, fewer than BA_DELAY): abort, CPU never loses phi2.
        lost_cpu = 0;
        rdy_low  = 0;
        for (int i = 0; i < 12; i++) begin
            tick_rand(i < 4);
            if (obs_phase && !obs_aec) lost_cpu++;
            if (!obs_rdy) rdy_low++;
        end
        check("pulse_cpu_phi2_lost", 32'(lost_cpu), 32'd0);
        check("pulse_rdy_low_clks",  32'(rdy_low),  32'd4);
        check("pulse_rdy_end",       32'(bus8.cpu_rdy),    32'd1);
        check("pulse_stolen",        32'(bus8.stolen_cnt), 32'd0);

        // Request held 20 pairs: 3 more CPU halves, then VIC owns everything.
        first_low = -1;
        ba_halves = 0;
        late_cpu  = 0;
        aec_back  = 1'b0;
        for (int i = 0; i < 44; i++) begin
            tick_rand(i < 40);
            if (!obs_rdy && first_low < 0) first_low = i;
            if (obs_phase && obs_aec && !obs_rdy) ba_halves++;
            if (i >= 8 && i < 43 && obs_aec) late_cpu++;
            if (i == 43) aec_back = obs_aec;
        end
        check("hold_rdy_fall_clk",     32'(first_low), 32'd2);
        check("hold_ba_cpu_halves",    32'(ba_halves), 32'd3);
        check("hold_vic_own_cpu_aec",  32'(late_cpu),  32'd0);
        check("hold_aec_back",         32'(aec_back),  32'd1);
        check("hold_stolen8",          32'(bus8.stolen_cnt), 32'd17);
        check("hold_stolen4_sat",      32'(bus4.stolen_cnt), 32'd15);

        // Reset during VIC_OWN releases the bus asynchronously.
        for (int i = 0; i < 14; i++) tick_rand(1'b1);
        check("dma_rdy_before_rst", 32'(bus8.cpu_rdy), 32'd0);
        do_reset("rst_dma");

        // Randomized traffic; request level changes occasionally, in any half.
        req = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) req = ~req;
            tick_rand(req);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
